// File: rtl/iir_biquad_cascade.sv
// iir_biquad_cascade: cascade of transposed DF-II biquads with runtime coefficients,
// per-section bypass, round-half-up and saturating outputs.
module iir_biquad_cascade #(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int N_SECTIONS = 2,
  parameter int ACC_WIDTH  = DATA_WIDTH + COEF_WIDTH + 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  input  logic [DATA_WIDTH-1:0]             x_in,
  output logic                              out_valid,
  output logic [DATA_WIDTH-1:0]             x_out,
  input  logic                              state_clr,
  input  logic                              cfg_we,
  input  logic [2+$clog2(N_SECTIONS):0]     cfg_addr,
  input  logic [COEF_WIDTH-1:0]             cfg_wdata,
  output logic [COEF_WIDTH-1:0]             cfg_rdata,
  output logic                              sat_flag
);
  localparam logic signed [COEF_WIDTH-1:0] ONE  = {2'b01, {(COEF_WIDTH-2){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0]  RND  = ACC_WIDTH'(1) << (COEF_WIDTH-3);
  localparam logic signed [ACC_WIDTH-1:0]  YMAX = ACC_WIDTH'({1'b0, {(DATA_WIDTH-1){1'b1}}});
  localparam logic signed [ACC_WIDTH-1:0]  YMIN = ~YMAX;
  logic signed [COEF_WIDTH-1:0] b0 [N_SECTIONS];
  logic signed [COEF_WIDTH-1:0] b1 [N_SECTIONS];
  logic signed [COEF_WIDTH-1:0] b2 [N_SECTIONS];
  logic signed [COEF_WIDTH-1:0] a1 [N_SECTIONS];
  logic signed [COEF_WIDTH-1:0] a2 [N_SECTIONS];
  logic [N_SECTIONS-1:0] byp;
  logic [N_SECTIONS-1:0] sat_ev;
  logic signed [DATA_WIDTH-1:0] dch [N_SECTIONS+1];
  logic [N_SECTIONS:0] vch;
  logic [COEF_WIDTH-1:0] rd;
  logic [2:0] idx;
  int sec;
  assign sec = int'(cfg_addr >> 3);
  assign idx = cfg_addr[2:0];
  assign dch[0] = x_in;
  assign vch[0] = in_valid;
  assign x_out = dch[N_SECTIONS];
  assign out_valid = vch[N_SECTIONS];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < N_SECTIONS; k++) begin
        b0[k] <= ONE;
        b1[k] <= '0;
        b2[k] <= '0;
        a1[k] <= '0;
        a2[k] <= '0;
      end
      byp <= '0;
    end else if (cfg_we) begin
      for (int k = 0; k < N_SECTIONS; k++)
        if (sec == k) begin
          if (idx == 3'd0) b0[k] <= cfg_wdata;
          if (idx == 3'd1) b1[k] <= cfg_wdata;
          if (idx == 3'd2) b2[k] <= cfg_wdata;
          if (idx == 3'd3) a1[k] <= cfg_wdata;
          if (idx == 3'd4) a2[k] <= cfg_wdata;
          if (idx == 3'd5) byp[k] <= cfg_wdata[0];
        end
    end
  always_comb begin
    rd = '0;
    for (int k = 0; k < N_SECTIONS; k++)
      if (sec == k)
        rd = idx == 3'd0 ? b0[k] : idx == 3'd1 ? b1[k] : idx == 3'd2 ? b2[k] :
             idx == 3'd3 ? a1[k] : idx == 3'd4 ? a2[k] :
             idx == 3'd5 ? COEF_WIDTH'(byp[k]) : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cfg_rdata <= '0;
    else cfg_rdata <= rd;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sat_flag <= 1'b0;
    else if (state_clr) sat_flag <= 1'b0;
    else if (|sat_ev) sat_flag <= 1'b1;
  for (genvar k = 0; k < N_SECTIONS; k++) begin : g_sec
    logic signed [ACC_WIDTH-1:0] s1, s2, xe, acc, ye, yf, s1_n, s2_n;
    logic signed [DATA_WIDTH-1:0] y, y_q;
    logic v_q, hi, lo;
    assign xe   = ACC_WIDTH'(dch[k]);
    assign acc  = ACC_WIDTH'(b0[k]) * xe + s1 + RND;
    assign ye   = acc >>> (COEF_WIDTH-2);
    assign hi   = ye > YMAX;
    assign lo   = ye < YMIN;
    assign y    = hi ? YMAX[DATA_WIDTH-1:0] : lo ? YMIN[DATA_WIDTH-1:0] : ye[DATA_WIDTH-1:0];
    // the clamped y, not the raw accumulator, drives the feedback
    assign yf   = ACC_WIDTH'(y);
    assign s1_n = ACC_WIDTH'(b1[k]) * xe - ACC_WIDTH'(a1[k]) * yf + s2;
    assign s2_n = ACC_WIDTH'(b2[k]) * xe - ACC_WIDTH'(a2[k]) * yf;
    assign sat_ev[k] = vch[k] & ~byp[k] & (hi | lo);
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        s1  <= '0;
        s2  <= '0;
        y_q <= '0;
        v_q <= 1'b0;
      end else if (state_clr) begin
        s1  <= '0;
        s2  <= '0;
        v_q <= 1'b0;
      end else begin
        v_q <= vch[k];
        if (vch[k]) begin
          y_q <= byp[k] ? dch[k] : y;
          if (!byp[k]) begin
            s1 <= s1_n;
            s2 <= s2_n;
          end
        end
      end
    assign dch[k+1] = y_q;
    assign vch[k+1] = v_q;
  end
endmodule

// File: tb/tb_iir_biquad_cascade.sv
// tb_iir_biquad_cascade: scoreboard bench for the biquad cascade with directed vectors.
module tb_iir_biquad_cascade;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, state_clr = 1'b0, cfg_we = 1'b0;
  logic [15:0] x_in = '0, cfg_wdata = '0;
  logic [3:0] cfg_addr = '0;
  logic out_valid, sat_flag;
  logic [15:0] x_out, cfg_rdata;
  int checks = 0, passes = 0;
  logic [15:0] exp_q[$];

  iir_biquad_cascade #(.DATA_WIDTH(16), .COEF_WIDTH(16), .N_SECTIONS(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x_in(x_in),
    .out_valid(out_valid), .x_out(x_out), .state_clr(state_clr),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata), .sat_flag(sat_flag));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk)
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_out: got %0d with nothing expected", $signed(x_out));
      end else check("x_out", {16'h0, x_out}, {16'h0, exp_q.pop_front()});
    end

  task automatic step(input logic v, input logic [15:0] x);
    in_valid = v;
    x_in = x;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] e);
    exp_q.push_back(e);
    step(1'b1, x);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [15:0] e);
    cfg_addr = a;
    @(negedge clk);
    check("cfg_rdata", {16'h0, cfg_rdata}, {16'h0, e});
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle(2);
    check("rst_x_out", {16'h0, x_out}, 0);
    check("rst_out_valid", {31'h0, out_valid}, 0);
    check("rst_cfg_rdata", {16'h0, cfg_rdata}, 0);
    check("rst_sat_flag", {31'h0, sat_flag}, 0);
    rst_n = 1'b1;
    idle(2);
    // identity and latency
    send(16'd1000, 16'd1000);
    check("lat_cycle1", {31'h0, out_valid}, 0);
    @(negedge clk);
    check("lat_cycle2", {31'h0, out_valid}, 1);
    drain();
    send(16'h8000, 16'h8000);
    send(16'h7FFF, 16'h7FFF);
    drain();
    // gain 0.5 with round half up
    wr(4'd0, 16'h2000);
    send(16'd16384, 16'd8192);
    send(16'd3, 16'd2);
    drain();
    // first-order recursion, states hold across idle gaps
    wr(4'd0, 16'h4000);
    wr(4'd3, 16'hE000);
    send(16'd1024, 16'd1024);
    idle(3);
    send(16'd0, 16'd512);
    idle(3);
    send(16'd0, 16'd256);
    idle(3);
    send(16'd0, 16'd128);
    idle(3);
    send(16'd0, 16'd64);
    drain();
    // saturation and sticky flag
    wr(4'd3, 16'h0000);
    wr(4'd0, 16'h7FFF);
    send(16'h7530, 16'h7FFF);
    drain();
    check("sat_set", {31'h0, sat_flag}, 1);
    send(16'h8AD0, 16'h8000);
    wr(4'd0, 16'h4000);
    send(16'd5, 16'd5);
    drain();
    check("sat_sticky", {31'h0, sat_flag}, 1);
    state_clr = 1'b1;
    @(negedge clk);
    state_clr = 1'b0;
    check("sat_cleared", {31'h0, sat_flag}, 0);
    // bypass of section 1 with nonzero feedback
    wr(4'd0, 16'h2000);
    wr(4'd11, 16'h1000);
    wr(4'd13, 16'h0001);
    send(16'd1000, 16'd500);
    send(16'd1000, 16'd500);
    drain();
    // readback
    rd(4'd0, 16'h2000);
    rd(4'd11, 16'h1000);
    rd(4'd13, 16'h0001);
    wr(4'd9, 16'h1234);
    rd(4'd9, 16'h1234);
    wr(4'd6, 16'h5555);
    rd(4'd6, 16'h0000);
    rd(4'd7, 16'h0000);
    wr(4'd4, 16'hF000);
    rd(4'd4, 16'hF000);
    wr(4'd13, 16'hFFFE);
    rd(4'd13, 16'h0000);
    wr(4'd9, 16'h0000);
    wr(4'd4, 16'h0000);
    wr(4'd11, 16'h0000);
    // write coinciding with strobe uses the old coefficient
    wr(4'd0, 16'h4000);
    cfg_we = 1'b1;
    cfg_addr = 4'd0;
    cfg_wdata = 16'h2000;
    send(16'd100, 16'd100);
    cfg_we = 1'b0;
    send(16'd100, 16'd50);
    drain();
    // asynchronous reset mid-decay
    wr(4'd0, 16'h4000);
    wr(4'd3, 16'hE000);
    send(16'd1024, 16'd1024);
    idle(3);
    send(16'd0, 16'd512);
    drain();
    exp_q.push_back(16'd256);
    step(1'b1, 16'd0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'h0, out_valid}, 0);
    check("midrst_x_out", {16'h0, x_out}, 0);
    check("midrst_cfg_rdata", {16'h0, cfg_rdata}, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    rd(4'd0, 16'h4000);
    rd(4'd3, 16'h0000);
    send(16'd77, 16'd77);
    drain();
    // state_clr drops in-flight and coincident samples and restarts the decay
    wr(4'd0, 16'h4000);
    wr(4'd3, 16'hE000);
    send(16'd1024, 16'd1024);
    idle(3);
    send(16'd0, 16'd512);
    drain();
    step(1'b1, 16'd0);
    state_clr = 1'b1;
    step(1'b1, 16'd999);
    state_clr = 1'b0;
    idle(4);
    send(16'd1024, 16'd1024);
    idle(2);
    send(16'd0, 16'd512);
    send(16'd0, 16'd256);
    drain();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
